// File: rtl/oled_fb_pkg.sv
// Shared constants, fetch FSM state type and pixel format conversion for the
// OLED frame-buffer reader.
package oled_fb_pkg;

  localparam int IMG_COLS  = 80;
  localparam int IMG_ROWS  = 60;
  localparam int OLED_COLS = 96;
  localparam int OLED_ROWS = 64;
  localparam int X_OFF     = 8;
  localparam int Y_OFF     = 2;
  localparam int ADDR_W    = 13;
  localparam int COL_W     = 7;
  localparam int ROW_W     = 6;

  localparam logic [15:0] BORDER_COLOR = 16'hC020;

  typedef enum logic [1:0] {
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_READY
  } fetch_state_t;

  // Buffer word is {r5, g5, b6}; RGB565 reuses the green MSB as the sixth
  // green bit and drops the blue LSB.
  function automatic logic [15:0] rgb556_to_565(input logic [15:0] w);
    return {w[15:11], w[10:6], w[10], w[5:1]};
  endfunction

endpackage

// File: rtl/oled_scan_counter.sv
// Raster position counter: column/row walk over the OLED raster, with a
// window flag for the centred image and a flag for the last raster position.
module oled_scan_counter
  import oled_fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             in_window,
  output logic             at_last
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OLED_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OLED_ROWS - 1);
  localparam logic [COL_W-1:0] X_LO     = COL_W'(X_OFF);
  localparam logic [COL_W-1:0] X_HI     = COL_W'(X_OFF + IMG_COLS);
  localparam logic [ROW_W-1:0] Y_LO     = ROW_W'(Y_OFF);
  localparam logic [ROW_W-1:0] Y_HI     = ROW_W'(Y_OFF + IMG_ROWS);

  // Step one position in raster order; clear returns to the origin.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign in_window = (col >= X_LO) && (col < X_HI) && (row >= Y_LO) && (row < Y_HI);
  assign at_last   = (col == LAST_COL) && (row == LAST_ROW);

endmodule

// File: rtl/oled_fb_reader.sv
// Frame-buffer reader for the OLED driver: prefetches the next raster pixel
// through the 1-cycle BRAM read, centres the image inside a border and
// converts it to RGB565.
//
// Handshake: ready=1 means the prefetched pixel for the next display position
// is held internally; a next_pixel pulse with ready=1 presents it on color and
// starts the following fetch. A pulse with ready=0 is an underrun: it is
// remembered once and executed as soon as the fetch completes.
module oled_fb_reader
  import oled_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              next_pixel,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [15:0]       fb_data,
  output logic [15:0]       color,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              ready,
  output logic              frame_done,
  output logic              underrun
);

  fetch_state_t      state;
  logic [15:0]       pre;
  logic [ADDR_W-1:0] addr_cnt;
  logic              first;
  logic              pending;

  logic step_now;
  logic disp_adv;
  logic fetch_adv;
  logic disp_last;
  logic disp_win_unused;
  logic fetch_in_win;
  logic fetch_last;
  logic [COL_W-1:0] fetch_col_unused;
  logic [ROW_W-1:0] fetch_row_unused;

  // The first fill after reset/sof presents itself; later ones wait for the
  // driver (or a pending underrun request).
  assign step_now  = (state == S_READY) && !sof && (first || pending || next_pixel);
  assign disp_adv  = step_now && !first;
  assign fetch_adv = step_now;

  oled_scan_counter u_disp (
    .clk       (clk),
    .rst       (rst),
    .clear     (sof),
    .advance   (disp_adv),
    .col       (col),
    .row       (row),
    .in_window (disp_win_unused),
    .at_last   (disp_last)
  );

  oled_scan_counter u_fetch (
    .clk       (clk),
    .rst       (rst),
    .clear     (sof),
    .advance   (fetch_adv),
    .col       (fetch_col_unused),
    .row       (fetch_row_unused),
    .in_window (fetch_in_win),
    .at_last   (fetch_last)
  );

  // Fetch FSM with registered outputs, address counter and underrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ADDR;
      fb_addr    <= '0;
      addr_cnt   <= '0;
      pre        <= BORDER_COLOR;
      color      <= BORDER_COLOR;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      pending    <= 1'b0;
      first      <= 1'b1;
    end else begin
      frame_done <= disp_adv && disp_last;
      if (sof) begin
        state    <= S_ADDR;
        addr_cnt <= '0;
        color    <= BORDER_COLOR;
        ready    <= 1'b0;
        pending  <= 1'b0;
        first    <= 1'b1;
      end else begin
        if (next_pixel && !ready) begin
          underrun <= 1'b1;
          pending  <= 1'b1;
        end
        case (state)
          S_ADDR: begin
            fb_addr <= addr_cnt;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            pre   <= fetch_in_win ? rgb556_to_565(fb_data) : BORDER_COLOR;
            ready <= 1'b1;
            state <= S_READY;
          end
          S_READY: begin
            if (step_now) begin
              color <= pre;
              ready <= 1'b0;
              state <= S_ADDR;
              if (fetch_last) begin
                addr_cnt <= '0;
              end else if (fetch_in_win) begin
                addr_cnt <= addr_cnt + 1'b1;
              end
              // A request arriving during the auto-present is kept for later;
              // otherwise the pending advance is consumed and extras dropped.
              if (first) begin
                first   <= 1'b0;
                pending <= pending || next_pixel;
              end else begin
                pending <= 1'b0;
              end
            end
          end
          default: state <= S_ADDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_fb_reader.sv
// Directed bench for oled_fb_reader: BRAM model, reset/timing checks, full
// frame walks, conversion words, underrun, sof and mid-fetch reset.
module tb_oled_fb_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sof = 1'b0;
  logic        next_pixel = 1'b0;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic [15:0] color;
  logic [6:0]  col;
  logic [5:0]  row;
  logic        ready;
  logic        frame_done;
  logic        underrun;

  oled_fb_reader dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .next_pixel (next_pixel),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .color      (color),
    .col        (col),
    .row        (row),
    .ready      (ready),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // BRAM model with 1-cycle read latency
  logic [15:0] mem [0:8191];
  always @(posedge clk) fb_data <= mem[fb_addr];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int fd_seen = 0;
  logic [15:0] exp_q[$];

  always @(negedge clk) if (frame_done) fd_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_color(input int x, input int y);
    logic [15:0] w;
    if (x >= 8 && x < 88 && y >= 2 && y < 62) begin
      w = mem[(y - 2) * 80 + (x - 8)];
      return {w[15:11], w[10:6], w[10], w[5:1]};
    end
    return 16'hC020;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({tag, "_ready_timeout"}, ready, 1);
  endtask

  task automatic pulse_next();
    next_pixel = 1'b1;
    @(negedge clk);
    next_pixel = 1'b0;
  endtask

  task automatic reset_seq(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_color"}, color, 16'hC020);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_fb_addr"}, fb_addr, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_c1"}, ready, 0);
    @(negedge clk);
    chk({tag, "_rdy_c2"}, ready, 0);
    @(negedge clk);
    chk({tag, "_rdy_c3"}, ready, 1);
    @(negedge clk);
    chk({tag, "_auto_color"}, color, 16'hC020);
    chk({tag, "_auto_col"}, col, 0);
    chk({tag, "_auto_ready"}, ready, 0);
  endtask

  // Walk display positions k0..k0+n-1, checking each shown pixel.
  task automatic run_pixels(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      int x;
      int y;
      x = k % 96;
      y = k / 96;
      wait_ready($sformatf("px_%0d_%0d", x, y));
      exp_q.push_back(exp_color(x, y));
      chk($sformatf("col_%0d_%0d", x, y), col, x);
      chk($sformatf("row_%0d_%0d", x, y), row, y);
      chk($sformatf("color_%0d_%0d", x, y), color, exp_q.pop_front());
      if (x == 7 && y == 2)   chk("fetch_addr_8_2", fb_addr, 0);
      if (x == 86 && y == 2)  chk("fetch_addr_87_2", fb_addr, 79);
      if (x == 7 && y == 3)   chk("fetch_addr_8_3", fb_addr, 80);
      if (x == 86 && y == 61) chk("fetch_addr_87_61", fb_addr, 4799);
      if (x == 8 && y == 2)   chk("conv_8061", color, 16'h8050);
      if (x == 9 && y == 2)   chk("conv_ffff", color, 16'hFFFF);
      pulse_next();
      chk($sformatf("frame_done_%0d_%0d", x, y), frame_done, (k == 6143) ? 1 : 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fd0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    mem[0] = 16'h8061;
    mem[1] = 16'hFFFF;

    // reset and a complete frame
    reset_seq("rst0");
    fd0 = fd_seen;
    run_pixels(0, 6144);
    @(negedge clk);
    chk("frame_done_once_0", fd_seen - fd0, 1);

    // underrun: second pulse one cycle after the first, third one dropped
    wait_ready("ur_start");
    chk("ur_start_col", col, 0);
    next_pixel = 1'b1;
    @(negedge clk);
    chk("ur_a_col", col, 1);
    chk("ur_a_underrun", underrun, 0);
    @(negedge clk);
    next_pixel = 1'b0;
    chk("ur_b_underrun", underrun, 1);
    @(negedge clk);
    next_pixel = 1'b1;
    @(negedge clk);
    next_pixel = 1'b0;
    chk("ur_hold_col", col, 1);
    chk("ur_hold_ready", ready, 1);
    @(negedge clk);
    chk("ur_pending_col", col, 2);
    repeat (12) @(negedge clk);
    chk("ur_drop_col", col, 2);
    chk("ur_sticky", underrun, 1);
    run_pixels(2, 2918);

    // sof together with next_pixel at (40,30)
    wait_ready("sof_start");
    chk("sof_start_col", col, 40);
    chk("sof_start_row", row, 30);
    sof = 1'b1;
    next_pixel = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    next_pixel = 1'b0;
    chk("sof_col", col, 0);
    chk("sof_row", row, 0);
    chk("sof_color", color, 16'hC020);
    chk("sof_ready_c1", ready, 0);
    chk("sof_underrun_kept", underrun, 1);
    @(negedge clk);
    chk("sof_ready_c2", ready, 0);
    @(negedge clk);
    chk("sof_ready_c3", ready, 0);
    @(negedge clk);
    chk("sof_ready_c4", ready, 1);
    @(negedge clk);
    chk("sof_auto_color", color, 16'hC020);
    chk("sof_auto_col", col, 0);
    run_pixels(0, 300);

    // reset while the BRAM read is in flight (S_WAIT)
    wait_ready("rst1_start");
    pulse_next();
    @(negedge clk);
    reset_seq("rst1");
    fd0 = fd_seen;
    run_pixels(0, 6144);
    @(negedge clk);
    chk("frame_done_once_1", fd_seen - fd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/oled_fb_reader.md
Name: oled_fb_reader

Overview:
- Sits between the camera frame buffer read port (port B) and the OLED video driver, downstream of the capture/frame-buffer stage.
- Walks the 96x64 OLED raster and fetches frame-buffer pixels through the BRAM's 1-cycle read latency. Each pixel is prefetched one position ahead, so the color output is always valid when the driver requests the next pixel.
- Centres the 80x60 image in the OLED raster with a fixed border color, and converts the buffer's {r5,g5,b6} format to RGB565.

Parameters:
- IMG_COLS, 80, image width in pixels
- IMG_ROWS, 60, image height in pixels
- OLED_COLS, 96, raster width
- OLED_ROWS, 64, raster height
- X_OFF, 8, first image column in the raster
- Y_OFF, 2, first image row in the raster
- ADDR_W, 13, frame-buffer address width
- BORDER_COLOR, 16'hC020, RGB565 value shown outside the image window

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- sof  in  1  start-of-frame pulse; restarts the scan
- next_pixel  in  1  pulse from the OLED driver: current color consumed
- fb_addr  out  ADDR_W  frame-buffer read address, registered
- fb_data  in  16  frame-buffer read data, valid 1 cycle after fb_addr
- color  out  16  RGB565 for position (col,row)
- col  out  7  current display column
- row  out  6  current display row
- ready  out  1  prefetch register valid
- frame_done  out  1  1-cycle pulse on raster wrap
- underrun  out  1  sticky; next_pixel arrived while ready=0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: color=BORDER_COLOR, col=0, row=0, fb_addr=0, ready=0, frame_done=0, underrun=0. Fetch position=(0,0). FSM=S_ADDR. The first fill is followed by an auto-present.
- Two raster positions are tracked:
  - display position (col,row), the pixel currently shown on color;
  - fetch position, always display+1 in steady state.
- Fetch FSM:
  - S_ADDR: fb_addr registered for the fetch position.
  - S_WAIT: BRAM read in flight.
  - S_LATCH: pre <= conv(fb_data) if the fetch position is inside the window, else BORDER_COLOR.
  - S_READY: ready=1.
- Fetch latency: 3 cycles from entering S_ADDR to ready=1. The driver guarantees next_pixel spacing >= 4 cycles.
- On next_pixel in S_READY:
  - color <= pre;
  - display position advances;
  - fetch position advances;
  - FSM -> S_ADDR.
- After reset or sof, the first completed fill is presented automatically: color <= pre, display=(0,0), then the fetch of (1,0) starts.
- Window test: X_OFF <= x < X_OFF+IMG_COLS and Y_OFF <= y < Y_OFF+IMG_ROWS.
- Frame-buffer address counter:
  - incremented after each in-window fetch;
  - holds outside the window;
  - cleared when the fetch position wraps to (0,0).
  - No multiplier is used.
- Position advance: col wraps OLED_COLS-1 -> 0 and increments row; row wraps OLED_ROWS-1 -> 0.
- frame_done pulses in the cycle after the display position wraps from (95,63) to (0,0).
- Conversion: out = {r5, g5, g5[4], b6[5:1]}.
- Underrun:
  - next_pixel while ready=0 sets underrun, which clears only on rst;
  - one advance is held pending and executed the cycle the FSM reaches S_READY;
  - further next_pixel pulses during the pending advance are dropped.
- sof:
  - clears both positions, the address counter, the pending flag and any in-flight fetch;
  - color <= BORDER_COLOR, ready=0, FSM=S_ADDR;
  - the underrun flag is unaffected.
- sof and next_pixel in the same cycle: sof wins and next_pixel is ignored.
- rst mid-fetch: all state returns to reset values the next cycle. Any returned fb_data is discarded.

Decomposition:
- Package oled_fb_pkg holds:
  - raster and image dimension constants;
  - BORDER_COLOR;
  - the FSM state enum (S_ADDR, S_WAIT, S_LATCH, S_READY);
  - the function rgb556_to_565.
- One sub-module, oled_scan_counter: col/row counter with advance, clear and in_window outputs. It is instantiated twice, once for the display position and once for the fetch position.

Test Plan:
- Reset, then idle -> ready=1 by cycle 3; auto-present; fb_addr=0 never read in-window at (0,0); color=16'hC020.
- Full frame of next_pixel pulses every 4 cycles, buffer loaded with data = addr:
  - at (8,2) the fetch read address is 0;
  - at (87,2) it is 79;
  - at (8,3) it is 80;
  - at (87,61) it is 4799;
  - all border positions show 16'hC020;
  - frame_done pulses exactly once, after (95,63).
- Buffer word {r=5'h10, g=5'h01, b=6'h21} at addr 0 -> color=16'h8050 at (8,2). Word 16'hFFFF -> 16'hFFFF.
- next_pixel 1 cycle after the previous one -> underrun=1; the advance completes once and col increments by exactly 1; a third pulse during the pending advance is dropped.
- sof mid-frame at (40,30) together with next_pixel -> col=0, row=0, color=16'hC020 next cycle, ready=0 for 3 cycles; the address counter restarts at 0.
- rst asserted during S_WAIT -> all outputs return to reset values; the following frame matches the full-frame scenario.
